// File: rtl/pixel_scan_ctrl_if.sv
// Host-side frame request/view bundle plus the per-group engine handshake of pixel_scan_ctrl.
// frame_cycles exists only when SCAN_FRAME_STATS_EN is defined.
interface pixel_scan_ctrl_if #(
  parameter int N = 32
);
  logic           frame_req;
  logic [N-1:0]   x_min_in;
  logic [N-1:0]   y_max_in;
  logic [1:0]     zoom_in;
  logic [3:0]     mbt_done;

  logic [15:0]    i_x;
  logic [15:0]    i_y;
  logic [N-1:0]   x_min;
  logic [N-1:0]   y_max;
  logic [1:0]     zoom_level;
  logic           rstMBT;
  logic           start;
  logic           busy;
  logic           frame_done;

`ifdef SCAN_FRAME_STATS_EN
  logic [31:0]    frame_cycles;

  modport master (
    input  frame_req, x_min_in, y_max_in, zoom_in, mbt_done,
    output i_x, i_y, x_min, y_max, zoom_level, rstMBT, start, busy, frame_done,
    output frame_cycles
  );

  modport slave (
    output frame_req, x_min_in, y_max_in, zoom_in, mbt_done,
    input  i_x, i_y, x_min, y_max, zoom_level, rstMBT, start, busy, frame_done,
    input  frame_cycles
  );
`else
  modport master (
    input  frame_req, x_min_in, y_max_in, zoom_in, mbt_done,
    output i_x, i_y, x_min, y_max, zoom_level, rstMBT, start, busy, frame_done
  );

  modport slave (
    output frame_req, x_min_in, y_max_in, zoom_in, mbt_done,
    input  i_x, i_y, x_min, y_max, zoom_level, rstMBT, start, busy, frame_done
  );
`endif
endinterface

// File: rtl/pixel_scan_ctrl.sv
// Raster frame sequencer: steps LANES pixels at a time, pulses engine reset/start and waits for all lanes.
// Define SCAN_FRAME_STATS_EN to add the saturating frame_cycles counter.
module pixel_scan_ctrl #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int LANES  = 4,
  parameter int N      = 32,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pixel_scan_ctrl_if.master bus
);

  localparam logic [15:0] X_LAST      = 16'(H_RES - LANES);
  localparam logic [15:0] Y_LAST      = 16'(V_RES - 1);
  localparam logic [16:0] X_LIM       = 17'(H_RES);
  localparam logic [16:0] X_STEP      = 17'(LANES);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SETTLE,
    S_GO,
    S_WAIT,
    S_ADV,
    S_FIN
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic [15:0]  i_x_q;
  logic [15:0]  i_y_q;
  logic [15:0]  x_nxt;
  logic [15:0]  y_nxt;
  logic [15:0]  settle_q;
  logic [15:0]  settle_nxt;
  logic [3:0]   mask_q;
  logic [3:0]   mask_nxt;
  logic [3:0]   mask_acc;
  logic         first_q;
  logic         first_nxt;
  logic         accept;

  logic [N-1:0] x_min_q;
  logic [N-1:0] y_max_q;
  logic [1:0]   zoom_q;
  logic         rst_mbt_q;
  logic         start_q;
  logic         busy_q;
  logic         frame_done_q;

  logic [16:0]  x_sum;
  logic         last_group;

  // 17-bit sum so the end-of-line test cannot wrap
  assign x_sum      = {1'b0, i_x_q} + X_STEP;
  assign last_group = (i_x_q == X_LAST) && (i_y_q == Y_LAST);

  always_comb begin
    state_nxt  = state;
    x_nxt      = i_x_q;
    y_nxt      = i_y_q;
    settle_nxt = settle_q;
    mask_nxt   = mask_q;
    mask_acc   = 4'b0000;
    first_nxt  = first_q;
    accept     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (bus.frame_req) begin
          accept    = 1'b1;
          x_nxt     = 16'd0;
          y_nxt     = 16'd0;
          state_nxt = S_CLR;
        end
      end

      S_CLR: begin
        settle_nxt = 16'd0;
        state_nxt  = (SETTLE == 0) ? S_GO : S_SETTLE;
      end

      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_nxt = 16'd0;
          state_nxt  = S_GO;
        end else begin
          settle_nxt = settle_q + 16'd1;
        end
      end

      S_GO: begin
        mask_nxt  = 4'b0000;
        first_nxt = 1'b1;
        state_nxt = S_WAIT;
      end

      // Done levels left over from the previous group are still visible on the first WAIT cycle
      S_WAIT: begin
        first_nxt = 1'b0;
        mask_acc  = first_q ? 4'b0000 : (mask_q | bus.mbt_done);
        mask_nxt  = mask_acc;
        if (mask_acc == 4'b1111) begin
          state_nxt = S_ADV;
        end
      end

      S_ADV: begin
        if (x_sum < X_LIM) begin
          x_nxt = x_sum[15:0];
        end else begin
          x_nxt = 16'd0;
          y_nxt = i_y_q + 16'd1;
        end
        state_nxt = last_group ? S_FIN : S_CLR;
      end

      S_FIN: begin
        x_nxt     = 16'd0;
        y_nxt     = 16'd0;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Pulse outputs are decoded from the next state so they line up with the state they name
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      i_x_q        <= 16'd0;
      i_y_q        <= 16'd0;
      settle_q     <= 16'd0;
      mask_q       <= 4'b0000;
      first_q      <= 1'b0;
      x_min_q      <= '0;
      y_max_q      <= '0;
      zoom_q       <= 2'd0;
      rst_mbt_q    <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      i_x_q        <= x_nxt;
      i_y_q        <= y_nxt;
      settle_q     <= settle_nxt;
      mask_q       <= mask_nxt;
      first_q      <= first_nxt;
      if (accept) begin
        x_min_q <= bus.x_min_in;
        y_max_q <= bus.y_max_in;
        zoom_q  <= bus.zoom_in;
      end
      rst_mbt_q    <= (state_nxt == S_CLR);
      start_q      <= (state_nxt == S_GO);
      busy_q       <= (state_nxt != S_IDLE);
      frame_done_q <= (state_nxt == S_FIN);
    end
  end

  assign bus.i_x        = i_x_q;
  assign bus.i_y        = i_y_q;
  assign bus.x_min      = x_min_q;
  assign bus.y_max      = y_max_q;
  assign bus.zoom_level = zoom_q;
  assign bus.rstMBT     = rst_mbt_q;
  assign bus.start      = start_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

`ifdef SCAN_FRAME_STATS_EN
  logic [31:0] cyc_cnt_q;
  logic [31:0] frame_cycles_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // cyc_cnt_q counts the acceptance cycle onward; the ADV and FIN cycles are added when FIN is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q      <= 32'd0;
      frame_cycles_q <= 32'd0;
    end else begin
      if (accept) begin
        cyc_cnt_q <= 32'd1;
      end else if (state != S_IDLE) begin
        cyc_cnt_q <= sat_inc(cyc_cnt_q);
      end
      if (state_nxt == S_FIN) begin
        frame_cycles_q <= sat_inc(sat_inc(cyc_cnt_q));
      end
    end
  end

  assign bus.frame_cycles = frame_cycles_q;
`endif

endmodule
